rename_recovery_controller: RTL
===============================

Name: rename_recovery_controller

Overview:
- Sequences rename-state recovery after a pipeline flush (branch mispredict, exception).
- Two modes, selected by recoveryMode: RECOVERY_FROM_RRMT (0) and RECOVERY_FROM_ACTIVE_LIST (1).
  - RRMT mode: bulk-copies the RRMT into the RMT in fixed chunks, then reloads the free list from committed state.
  - Active-list mode: walks squashed active-list entries youngest-to-oldest. Each entry restores its previous mapping into the RMT and returns its new physical register to the free list.
- Sits between the active list, RMT and free list.
- Stalls rename while it runs.

Parameters:
- WALK_WIDTH, 2, active-list entries restored per cycle.
- AL_ENTRY_NUM, 64, active-list depth (power of 2).
- AL_INDEX_WIDTH, 6, log2(AL_ENTRY_NUM).
- LREG_WIDTH, 5, logical register index width (RMT_INDEX_BIT_SIZE).
- PREG_WIDTH, 7, RMT entry width (RMT_ENTRY_BIT_SIZE).
- RRMT_COPY_WIDTH, 8, RMT entries copied per cycle in RRMT mode (divides 2^LREG_WIDTH).

Ports:
- clk  in  1  clock
- rstN  in  1  asynchronous active-low reset
- recoveryReq  in  1  start pulse; sampled only in IDLE
- recoveryMode  in  1  0 = RRMT, 1 = active list
- flushHead  in  AL_INDEX_WIDTH  oldest squashed active-list index
- flushCount  in  AL_INDEX_WIDTH+1  squashed entries, 0..AL_ENTRY_NUM
- alReadIdx  out  WALK_WIDTH*AL_INDEX_WIDTH  active-list read indices
- alReadEn  out  WALK_WIDTH  per-lane read valid
- alWriteReg  in  WALK_WIDTH  entry has a destination (data valid 1 cycle after alReadEn)
- alLogReg  in  WALK_WIDTH*LREG_WIDTH  destination logical register
- alPrevPhy  in  WALK_WIDTH*PREG_WIDTH  mapping to restore
- alNewPhy  in  WALK_WIDTH*PREG_WIDTH  register to free
- rmtWE  out  WALK_WIDTH  RMT restore write enables
- rmtWAddr  out  WALK_WIDTH*LREG_WIDTH  RMT restore addresses
- rmtWData  out  WALK_WIDTH*PREG_WIDTH  RMT restore data
- freeListPush  out  WALK_WIDTH  free-list push enables
- freeListPushData  out  WALK_WIDTH*PREG_WIDTH  registers pushed to the free list
- rrmtCopyEn  out  1  copy RRMT[base..base+RRMT_COPY_WIDTH-1] to RMT
- rrmtCopyBase  out  LREG_WIDTH  copy base index
- freeListRestore  out  1  one-cycle pulse: free list reloads from committed pointers
- renameStall  out  1  recoveryReq OR (state != IDLE)
- recoveryDone  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, WALK, DRAIN, COPY, DONE.
- Reset (rstN low, any time including mid-walk): state = IDLE, counters 0, every registered output 0. No partial writes after deassertion.
- IDLE + recoveryReq at cycle T:
  - Latch mode, flushHead, flushCount.
  - If mode = 1 and flushCount = 0: go to DONE at T+1.
  - Otherwise mode 1 goes to WALK; mode 0 goes to COPY.
- WALK, each cycle:
  - Issue up to WALK_WIDTH reads. Lane i index = (flushHead + remaining - 1 - i) mod AL_ENTRY_NUM, so lane 0 is the youngest entry.
  - alReadEn[i] = (i < remaining); remaining -= min(remaining, WALK_WIDTH).
  - Index arithmetic wraps modulo AL_ENTRY_NUM, with no special case at index 0.
  - When remaining reaches 0: go to DRAIN.
- Read-to-write pipeline:
  - Read data returns 1 cycle after alReadEn.
  - In that cycle: rmtWE[i] = lane i valid AND alWriteReg[i]; freeListPush[i] uses the same condition.
  - rmtWAddr = alLogReg, rmtWData = alPrevPhy, freeListPushData = alNewPhy.
- Intra-group conflict: if lanes i < j both write the same alLogReg, rmtWE[i] is suppressed so the older mapping wins. freeListPush is unaffected.
- Inter-cycle ordering: later cycles hold older entries, so they overwrite correctly.
- DRAIN: emits the final write group, then goes to DONE.
  - Active-list latency from req T = ceil(count/WALK_WIDTH) + 2 cycles to DONE.
- COPY:
  - Cycles k = 0..(2^LREG_WIDTH / RRMT_COPY_WIDTH) - 1: rrmtCopyEn = 1, rrmtCopyBase = k*RRMT_COPY_WIDTH.
  - freeListRestore pulses in cycle k = 0.
  - After the last chunk: go to DONE.
- DONE: recoveryDone = 1 for exactly one cycle, then go to IDLE. renameStall is still high in DONE and low the cycle after.
- recoveryReq while not IDLE: ignored, with no effect on state. The bench flags it as a protocol error.
- flushCount > AL_ENTRY_NUM: undefined; asserted in simulation.

Decomposition:
- Add to package RenameLogicTypes:
  - RecoveryStateType enum (IDLE/WALK/DRAIN/COPY/DONE).
  - RRMT_COPY_WIDTH localparam.
  - RecoveryWalkEntry struct {writeReg, logReg, prevPhy, newPhy}.
  - Reuse RECOVERY_FROM_RRMT / RECOVERY_FROM_ACTIVE_LIST as the recoveryMode encoding.
- One combinational sub-module, rename_recovery_conflict_filter: same-group lreg compare and older-wins write-enable masking.
- The FSM and index counters stay in the top module.

Test Plan:
- Mode 1, flushHead=10, flushCount=5, WALK_WIDTH=2, all entries writeReg:
  - Reads {14,13}, {12,11}, {10,-}.
  - 5 RMT restores and 5 pushes.
  - recoveryDone at T+5.
- Wrap: flushHead=62, flushCount=4 -> reads {1,0}, {63,62}; restores in that order.
- Conflict: entries 21 and 20 both write lreg 3 (prevPhy 40, 33) in one group -> only rmtWData=33 written to addr 3; both newPhys pushed.
- flushCount=0, mode 1 -> no rmtWE/freeListPush; recoveryDone at T+1; renameStall high in T and T+1 only.
- Mode 0 -> rrmtCopyEn for 4 cycles with bases 0,8,16,24; freeListRestore only in the first; recoveryDone in the 5th cycle.
- rstN low mid-WALK (count 20, after 3 cycles) -> all outputs 0 immediately; IDLE after release. A new req with mode 0 then runs cleanly. A second recoveryReq sent during WALK is ignored.

Source files
------------

// File: rtl/rename_recovery_controller_pkg.sv
// Shared types for rename-state recovery.
//   RecoveryStateType  : recovery sequencer states
//   RecoveryWalkEntry  : one squashed active-list entry as seen by the walker
//   RECOVERY_FROM_*    : recoveryMode encoding
package RenameLogicTypes;

    localparam int unsigned RMT_INDEX_BIT_SIZE = 5;
    localparam int unsigned RMT_ENTRY_BIT_SIZE = 7;
    localparam int unsigned RRMT_COPY_WIDTH    = 8;

    localparam logic RECOVERY_FROM_RRMT        = 1'b0;
    localparam logic RECOVERY_FROM_ACTIVE_LIST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        DRAIN,
        COPY,
        DONE
    } RecoveryStateType;

    typedef struct packed {
        logic                          writeReg;
        logic [RMT_INDEX_BIT_SIZE-1:0] logReg;
        logic [RMT_ENTRY_BIT_SIZE-1:0] prevPhy;
        logic [RMT_ENTRY_BIT_SIZE-1:0] newPhy;
    } RecoveryWalkEntry;

endpackage

// File: rtl/rename_recovery_controller_conflict_filter.sv
// Same-group RMT write conflict filter.
// Lane 0 holds the youngest entry of a walk group. When two writing lanes target the same
// logical register, the younger lane is masked so the older (pre-squash) mapping is what
// lands in the RMT.
//   we_i   : per-lane raw write enables
//   lreg_i : per-lane destination logical registers (lane 0 in the low bits)
//   we_o   : filtered write enables
module rename_recovery_conflict_filter
    import RenameLogicTypes::*;
#(
    parameter int unsigned WALK_WIDTH = 2,
    parameter int unsigned LREG_WIDTH = 5
) (
    input  logic [WALK_WIDTH-1:0]            we_i,
    input  logic [WALK_WIDTH*LREG_WIDTH-1:0] lreg_i,
    output logic [WALK_WIDTH-1:0]            we_o
);

    always_comb begin
        we_o = we_i;
        for (int i = 0; i < WALK_WIDTH; i++) begin
            for (int j = i + 1; j < WALK_WIDTH; j++) begin
                if (we_i[j] && (lreg_i[j*LREG_WIDTH +: LREG_WIDTH] ==
                                lreg_i[i*LREG_WIDTH +: LREG_WIDTH])) begin
                    we_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rename_recovery_controller.sv
// Rename-state recovery sequencer, run after a pipeline flush.
//   RRMT mode        : bulk-copies RRMT -> RMT in fixed chunks, pulses a free-list reload.
//   Active-list mode : walks squashed entries youngest-first, restoring previous mappings
//                      into the RMT and returning new physical registers to the free list.
// Ports:
//   recoveryReq/Mode, flushHead, flushCount : start request (sampled in IDLE only)
//   alReadIdx/alReadEn                      : active-list read port (lane 0 = youngest)
//   alWriteReg/alLogReg/alPrevPhy/alNewPhy  : active-list read data, one cycle after read
//   rmtWE/rmtWAddr/rmtWData                 : RMT restore writes
//   freeListPush/freeListPushData           : free-list returns
//   rrmtCopyEn/rrmtCopyBase                 : RRMT chunk copy
//   freeListRestore                         : free-list reload pulse (first copy chunk)
//   renameStall, recoveryDone               : rename stall and completion pulse
module rename_recovery_controller #(
    parameter int unsigned WALK_WIDTH      = 2,
    parameter int unsigned AL_ENTRY_NUM    = 64,
    parameter int unsigned AL_INDEX_WIDTH  = 6,
    parameter int unsigned LREG_WIDTH      = RenameLogicTypes::RMT_INDEX_BIT_SIZE,
    parameter int unsigned PREG_WIDTH      = RenameLogicTypes::RMT_ENTRY_BIT_SIZE,
    parameter int unsigned RRMT_COPY_WIDTH = RenameLogicTypes::RRMT_COPY_WIDTH
) (
    input  logic                                clk,
    input  logic                                rstN,
    input  logic                                recoveryReq,
    input  logic                                recoveryMode,
    input  logic [AL_INDEX_WIDTH-1:0]           flushHead,
    input  logic [AL_INDEX_WIDTH:0]             flushCount,
    output logic [WALK_WIDTH*AL_INDEX_WIDTH-1:0] alReadIdx,
    output logic [WALK_WIDTH-1:0]               alReadEn,
    input  logic [WALK_WIDTH-1:0]               alWriteReg,
    input  logic [WALK_WIDTH*LREG_WIDTH-1:0]    alLogReg,
    input  logic [WALK_WIDTH*PREG_WIDTH-1:0]    alPrevPhy,
    input  logic [WALK_WIDTH*PREG_WIDTH-1:0]    alNewPhy,
    output logic [WALK_WIDTH-1:0]               rmtWE,
    output logic [WALK_WIDTH*LREG_WIDTH-1:0]    rmtWAddr,
    output logic [WALK_WIDTH*PREG_WIDTH-1:0]    rmtWData,
    output logic [WALK_WIDTH-1:0]               freeListPush,
    output logic [WALK_WIDTH*PREG_WIDTH-1:0]    freeListPushData,
    output logic                                rrmtCopyEn,
    output logic [LREG_WIDTH-1:0]               rrmtCopyBase,
    output logic                                freeListRestore,
    output logic                                renameStall,
    output logic                                recoveryDone
);

    import RenameLogicTypes::*;

    localparam logic [AL_INDEX_WIDTH:0] WalkStep = (AL_INDEX_WIDTH+1)'(WALK_WIDTH);
    localparam logic [LREG_WIDTH-1:0]   CopyStep = LREG_WIDTH'(RRMT_COPY_WIDTH);
    localparam logic [LREG_WIDTH-1:0]   LastCopyBase =
        LREG_WIDTH'((1 << LREG_WIDTH) - RRMT_COPY_WIDTH);

    RecoveryStateType                state_q, state_d;
    logic [AL_INDEX_WIDTH-1:0]       head_q, head_d;
    logic [AL_INDEX_WIDTH:0]         remain_q, remain_d;
    logic [LREG_WIDTH-1:0]           copy_base_q, copy_base_d;
    // Lanes whose read was issued last cycle; their data is on the al* inputs now.
    logic [WALK_WIDTH-1:0]           lane_valid_q, lane_valid_d;

    logic [AL_INDEX_WIDTH-1:0]       lane_idx [WALK_WIDTH];
    RecoveryWalkEntry                lane_entry [WALK_WIDTH];
    logic [WALK_WIDTH-1:0]           lane_we;

    // Lane i reads (head + remaining - 1 - i) mod depth; the truncation gives the wrap.
    for (genvar g = 0; g < WALK_WIDTH; g++) begin : g_lane
        logic [AL_INDEX_WIDTH:0] lane_sum;
        assign lane_sum    = {1'b0, head_q} + remain_q - (AL_INDEX_WIDTH+1)'(g + 1);
        assign lane_idx[g] = lane_sum[AL_INDEX_WIDTH-1:0];

        assign lane_entry[g] = '{
            writeReg: alWriteReg[g],
            logReg:   alLogReg[g*LREG_WIDTH +: LREG_WIDTH],
            prevPhy:  alPrevPhy[g*PREG_WIDTH +: PREG_WIDTH],
            newPhy:   alNewPhy[g*PREG_WIDTH +: PREG_WIDTH]
        };
        assign lane_we[g] = lane_valid_q[g] & lane_entry[g].writeReg;

        // Data buses are held at zero unless the lane actually writes.
        assign rmtWAddr[g*LREG_WIDTH +: LREG_WIDTH] =
            lane_we[g] ? lane_entry[g].logReg : '0;
        assign rmtWData[g*PREG_WIDTH +: PREG_WIDTH] =
            lane_we[g] ? lane_entry[g].prevPhy : '0;
        assign freeListPushData[g*PREG_WIDTH +: PREG_WIDTH] =
            lane_we[g] ? lane_entry[g].newPhy : '0;
    end

    assign freeListPush = lane_we;
    assign lane_valid_d = alReadEn;
    assign renameStall  = recoveryReq | (state_q != IDLE);

    rename_recovery_conflict_filter #(
        .WALK_WIDTH (WALK_WIDTH),
        .LREG_WIDTH (LREG_WIDTH)
    ) u_conflict_filter (
        .we_i   (lane_we),
        .lreg_i (alLogReg),
        .we_o   (rmtWE)
    );

    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        remain_d        = remain_q;
        copy_base_d     = copy_base_q;
        alReadEn        = '0;
        alReadIdx       = '0;
        rrmtCopyEn      = 1'b0;
        rrmtCopyBase    = '0;
        freeListRestore = 1'b0;
        recoveryDone    = 1'b0;

        case (state_q)
            IDLE: begin
                if (recoveryReq) begin
                    head_d      = flushHead;
                    remain_d    = flushCount;
                    copy_base_d = '0;
                    if (recoveryMode == RECOVERY_FROM_ACTIVE_LIST) begin
                        state_d = (flushCount == '0) ? DONE : WALK;
                    end else begin
                        state_d = COPY;
                    end
                end
            end
            WALK: begin
                for (int i = 0; i < WALK_WIDTH; i++) begin
                    if (remain_q > (AL_INDEX_WIDTH+1)'(i)) begin
                        alReadEn[i] = 1'b1;
                        alReadIdx[i*AL_INDEX_WIDTH +: AL_INDEX_WIDTH] = lane_idx[i];
                    end
                end
                if (remain_q > WalkStep) begin
                    remain_d = remain_q - WalkStep;
                end else begin
                    remain_d = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                // Last read group's data is being written this cycle.
                state_d = DONE;
            end
            COPY: begin
                rrmtCopyEn      = 1'b1;
                rrmtCopyBase    = copy_base_q;
                freeListRestore = (copy_base_q == '0);
                if (copy_base_q == LastCopyBase) begin
                    copy_base_d = '0;
                    state_d     = DONE;
                end else begin
                    copy_base_d = copy_base_q + CopyStep;
                end
            end
            DONE: begin
                recoveryDone = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            head_q       <= '0;
            remain_q     <= '0;
            copy_base_q  <= '0;
            lane_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            remain_q     <= remain_d;
            copy_base_q  <= copy_base_d;
            lane_valid_q <= lane_valid_d;
        end
    end

    // A flush larger than the active list has no meaning.
    always_ff @(posedge clk) begin
        if (rstN && (state_q == IDLE) && recoveryReq &&
            (recoveryMode == RECOVERY_FROM_ACTIVE_LIST)) begin
            assert (flushCount <= (AL_INDEX_WIDTH+1)'(AL_ENTRY_NUM));
        end
    end

endmodule
